// File: rtl/bf_pkg.sv
// Shared definitions for the bracket-loop controller: opcode bytes, FSM states
// and the default code address width.
package bf_pkg;

  localparam int ADDR_SIZE_DEFAULT = 9;

  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_INC        = 8'h2B;
  localparam logic [7:0] OP_DEC        = 8'h2D;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    SCAN,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/bf_addr_stack.sv
// LIFO of loop-start code addresses. At most one of push/pop acts per cycle;
// a push while full or a pop while empty is ignored (the controller flags it).
module bf_addr_stack
  import bf_pkg::*;
#(
  parameter int ADDR_SIZE   = ADDR_SIZE_DEFAULT,
  parameter int STACK_DEPTH = 16,
  localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [ADDR_SIZE-1:0] data_i,
  output logic [ADDR_SIZE-1:0] top_o,
  output logic [SP_W-1:0]      sp_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_SIZE-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]      sp_q;
  logic [PTR_W-1:0]     wrIdx;
  logic [PTR_W-1:0]     topIdx;
  logic                 doPush;
  logic                 doPop;

  assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o && !push_i;
  assign wrIdx   = sp_q[PTR_W-1:0];
  assign topIdx  = PTR_W'(sp_q - SP_W'(1));
  assign top_o   = empty_o ? '0 : mem_q[topIdx];
  assign sp_o    = sp_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q <= '0;
    end else if (doPush) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (doPop) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end

  // Entry storage needs no reset: only slots below sp are ever read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrIdx] <= data_i;
    end
  end

endmodule

// File: rtl/bf_loop_ctrl.sv
// Loop controller for a bracket-language core: resolves '[' and ']' into the
// next code address, using a return-address stack or a forward bracket scan.
module bf_loop_ctrl
  import bf_pkg::*;
#(
  parameter int ADDR_SIZE   = ADDR_SIZE_DEFAULT,
  parameter int STACK_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  input  logic                           op,
  input  logic                           cell_zero,
  input  logic [ADDR_SIZE-1:0]           pc,
  output logic [ADDR_SIZE-1:0]           scan_addr,
  input  logic [7:0]                     scan_data,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_SIZE-1:0]           new_pc,
  output logic                           err,
  output logic [$clog2(STACK_DEPTH):0]   sp
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  state_e               state_q;
  logic                 opClose_q;
  logic                 cellZero_q;
  logic [ADDR_SIZE-1:0] pc_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [ADDR_SIZE-1:0] newPc_q;
  logic [ADDR_SIZE-1:0] scanAddr_q;
  logic [ADDR_SIZE-1:0] depth_q;
  logic                 scanArmed_q;

  logic                 stackPush;
  logic                 stackPop;
  logic [ADDR_SIZE-1:0] stackTop;
  logic [SP_W-1:0]      stackSp;
  logic                 stackFull;
  logic                 stackEmpty;
  logic                 stackErr;
  logic                 scanMatch;

  bf_addr_stack #(
    .ADDR_SIZE  (ADDR_SIZE),
    .STACK_DEPTH(STACK_DEPTH)
  ) uStack (
    .clk    (clk),
    .reset  (reset),
    .push_i (stackPush),
    .pop_i  (stackPop),
    .data_i (pc_q),
    .top_o  (stackTop),
    .sp_o   (stackSp),
    .full_o (stackFull),
    .empty_o(stackEmpty)
  );

  // The stack acts only in EXEC, so a single request moves it by at most one entry.
  assign stackErr  = opClose_q ? stackEmpty : stackFull;
  assign stackPush = (state_q == EXEC) && !opClose_q && !stackFull;
  assign stackPop  = (state_q == EXEC) && opClose_q && cellZero_q && !stackEmpty;
  assign scanMatch = (scan_data == OP_LOOP_CLOSE) && (depth_q == ADDR_SIZE'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      opClose_q   <= 1'b0;
      cellZero_q  <= 1'b0;
      pc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      newPc_q     <= '0;
      scanAddr_q  <= '0;
      depth_q     <= '0;
      scanArmed_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            opClose_q   <= op;
            cellZero_q  <= cell_zero;
            pc_q        <= pc;
            busy_q      <= 1'b1;
            scanArmed_q <= 1'b0;
            state_q     <= (!op && cell_zero) ? SCAN : EXEC;
          end
        end
        EXEC: begin
          busy_q <= 1'b0;
          if (stackErr) begin
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else begin
            done_q  <= 1'b1;
            newPc_q <= (opClose_q && !cellZero_q) ? stackTop + ADDR_SIZE'(1)
                                                  : pc_q + ADDR_SIZE'(1);
            state_q <= DONE;
          end
        end
        SCAN: begin
          // The first SCAN cycle only arms the address and depth counters.
          if (!scanArmed_q) begin
            if (pc_q == '1) begin
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ERROR;
            end else begin
              scanAddr_q  <= pc_q + ADDR_SIZE'(1);
              depth_q     <= ADDR_SIZE'(1);
              scanArmed_q <= 1'b1;
            end
          end else if (scanMatch) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            newPc_q <= scanAddr_q + ADDR_SIZE'(1);
            depth_q <= '0;
            state_q <= DONE;
          end else begin
            if (scan_data == OP_LOOP_OPEN) begin
              depth_q <= depth_q + ADDR_SIZE'(1);
            end else if (scan_data == OP_LOOP_CLOSE) begin
              depth_q <= depth_q - ADDR_SIZE'(1);
            end
            if (scanAddr_q == '1) begin
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ERROR;
            end else begin
              scanAddr_q <= scanAddr_q + ADDR_SIZE'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        ERROR: begin
          state_q <= ERROR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign scan_addr = scanAddr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign new_pc    = newPc_q;
  assign err       = err_q;
  assign sp        = stackSp;

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Self-checking bench for bf_loop_ctrl: directed cases plus random bracket
// programs checked against a queue-based model of the loop semantics.
module tb_bf_loop_ctrl;

  localparam int ADDR_SIZE   = 9;
  localparam int STACK_DEPTH = 16;
  localparam int MEM_SIZE    = 1 << ADDR_SIZE;
  localparam int BUDGET      = 700;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req;
  logic                 op;
  logic                 cell_zero;
  logic [ADDR_SIZE-1:0] pc;
  logic [ADDR_SIZE-1:0] scan_addr;
  logic [7:0]           scan_data;
  logic                 busy;
  logic                 done;
  logic [ADDR_SIZE-1:0] new_pc;
  logic                 err;
  logic [4:0]           sp;

  logic [7:0] codeMem [MEM_SIZE];
  int         refStack[$];
  int         checks   = 0;
  int         failures = 0;

  assign scan_data = codeMem[scan_addr];

  bf_loop_ctrl #(
    .ADDR_SIZE  (ADDR_SIZE),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .op       (op),
    .cell_zero(cell_zero),
    .pc       (pc),
    .scan_addr(scan_addr),
    .scan_data(scan_data),
    .busy     (busy),
    .done     (done),
    .new_pc   (new_pc),
    .err      (err),
    .sp       (sp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    refStack.delete();
    checkOutput("rst_sp", 32'(sp), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
  endtask

  function automatic logic [7:0] pickByte();
    int r = $urandom_range(0, 9);
    if (r == 0) return 8'h5B;
    if (r == 1) return 8'h5D;
    if (r < 4)  return 8'h2B;
    if (r < 6)  return 8'h2D;
    return 8'h2E;
  endfunction

  task automatic loadNested();
    string prog = "[+[-]+]x";
    for (int i = 0; i < MEM_SIZE; i++) codeMem[i] = 8'h2B;
    for (int i = 0; i < prog.len(); i++) codeMem[i] = prog[i];
  endtask

  // Predicts the outcome from the loop rules, issues one request, checks it.
  task automatic applyStimulus(input logic o, input logic cz, input int p);
    bit expErr   = 0;
    int expPc    = 0;
    int expLat   = 2;
    int k        = 1;
    bit sawDone  = 0;
    bit sawErr   = 0;
    if (!o && cz) begin
      int d = 1;
      int a = p + 1;
      bit found = 0;
      while (a < MEM_SIZE) begin
        if (codeMem[a] == 8'h5B) d++;
        else if (codeMem[a] == 8'h5D) begin
          d--;
          if (d == 0) begin found = 1; break; end
        end
        a++;
      end
      expErr = !found;
      expLat = (a - p) + 2;
      expPc  = (a + 1) % MEM_SIZE;
    end else if (!o) begin
      if (refStack.size() == STACK_DEPTH) expErr = 1;
      else begin refStack.push_back(p); expPc = (p + 1) % MEM_SIZE; end
    end else if (refStack.size() == 0) begin
      expErr = 1;
    end else if (!cz) begin
      expPc = (refStack[$] + 1) % MEM_SIZE;
    end else begin
      void'(refStack.pop_back());
      expPc = (p + 1) % MEM_SIZE;
    end

    @(negedge clk);
    req       = 1'b1;
    op        = o;
    cell_zero = cz;
    pc        = ADDR_SIZE'(p);
    @(negedge clk);
    req       = 1'b0;
    op        = 1'($urandom);
    pc        = ADDR_SIZE'($urandom);
    while (k <= BUDGET) begin
      if (done === 1'b1) begin sawDone = 1; break; end
      if (err === 1'b1) begin sawErr = 1; break; end
      @(negedge clk);
      k++;
    end

    if (!expErr) begin
      checkOutput("done_seen", 32'(sawDone), 1);
      checkOutput("latency", k, expLat);
      checkOutput("new_pc", 32'(new_pc), expPc);
      checkOutput("sp", 32'(sp), refStack.size());
      checkOutput("busy_in_done", 32'(busy), 0);
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 0);
    end else begin
      checkOutput("err_seen", 32'(sawErr), 1);
      checkOutput("err_no_done", 32'(sawDone), 0);
      checkOutput("err_busy", 32'(busy), 0);
      checkOutput("err_sp", 32'(sp), refStack.size());
      repeat (3) @(negedge clk);
      checkOutput("err_sticky", 32'(err), 1);
      checkOutput("err_still_no_done", 32'(done), 0);
      doReset();
    end
  endtask

  initial begin
    int doneCount;
    reset     = 1'b1;
    req       = 1'b0;
    op        = 1'b0;
    cell_zero = 1'b0;
    pc        = '0;
    loadNested();

    doReset();
    checkOutput("rst_new_pc", 32'(new_pc), 0);
    checkOutput("rst_scan_addr", 32'(scan_addr), 0);

    $display("[TB] push, loop-back, exit");
    applyStimulus(1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 9);
    applyStimulus(1'b1, 1'b1, 9);

    $display("[TB] nested forward scan");
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("scan_new_pc_7", 32'(new_pc), 7);

    $display("[TB] error cases");
    applyStimulus(1'b1, 1'b0, 3);
    for (int i = 0; i < STACK_DEPTH + 1; i++) applyStimulus(1'b0, 1'b0, 3 * i);
    for (int i = 0; i < MEM_SIZE; i++) codeMem[i] = 8'h2B;
    codeMem[0] = 8'h5B;
    applyStimulus(1'b0, 1'b1, 0);

    $display("[TB] reset during scan");
    loadNested();
    applyStimulus(1'b0, 1'b0, 20);
    @(negedge clk);
    req       = 1'b1;
    op        = 1'b0;
    cell_zero = 1'b1;
    pc        = '0;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midscan_busy", 32'(busy), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    refStack.delete();
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_sp", 32'(sp), 0);
    checkOutput("abort_done", 32'(done), 0);
    doneCount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("abort_no_done", doneCount, 0);
    applyStimulus(1'b0, 1'b1, 0);

    $display("[TB] random programs");
    for (int i = 0; i < MEM_SIZE; i++) codeMem[i] = pickByte();
    for (int n = 0; n < 40; n++) begin
      logic o;
      o = (refStack.size() == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus(o, 1'($urandom_range(0, 1)), $urandom_range(0, MEM_SIZE - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
